// File: rtl/l0_pkg.sv
// Shared types and constants for the layer-0 max-pool stage.
package l0_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } l0_pool_state_t;

  localparam int unsigned L0_POOL_DIM   = 13;
  localparam int unsigned L0_POOL_N_WIN = L0_POOL_DIM * L0_POOL_DIM;

endpackage

// File: rtl/l0_pool_sat.sv
// Per-channel window reduction: unsigned max, right shift, saturate to OUT_W.
module l0_pool_sat #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned OUT_W  = 18,
  parameter int unsigned SHIFT  = 0
) (
  input  logic [DATA_W-1:0] mx_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] max_o,
  output logic [OUT_W-1:0]  q_o
);

  logic [DATA_W-1:0] shifted;

  // Running max of the accumulated value and the incoming sample.
  always_comb begin
    max_o = (din_i > mx_i) ? din_i : mx_i;
  end

  assign shifted = max_o >> SHIFT;

  generate
    if (OUT_W >= DATA_W) begin : g_wide
      assign q_o = OUT_W'(shifted);
    end else begin : g_narrow
      assign q_o = (|shifted[DATA_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write on we_i; read returns the pre-write contents one cycle later.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l0_maxpool.sv
// 2x2 max-pool stage after layer 0: reduces 4-beat windows on two channels
// to their max, rescales/saturates, and stores results in per-channel RAMs.
module l0_maxpool
  import l0_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned OUT_W  = 18,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned N_WIN  = L0_POOL_N_WIN,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_done,
  input  logic              win_vld,
  input  logic              win_first,
  input  logic [DATA_W-1:0] din_0,
  input  logic [DATA_W-1:0] din_1,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rdy,
  output logic [OUT_W-1:0]  dout_0,
  output logic [OUT_W-1:0]  dout_1,
  output logic              frame_done,
  output logic              err
);

  // One extra bit so the write count can reach 2**ADDR_W without wrapping.
  localparam int unsigned          CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]     LAST_WR = CNT_W'(N_WIN - 1);

  l0_pool_state_t    state_q, state_d;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] mx_0_q, mx_0_d, mx_1_q, mx_1_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              wr;
  logic [DATA_W-1:0] max_0, max_1;
  logic [OUT_W-1:0]  q_0, q_1;

  l0_pool_sat #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_0 (
    .mx_i (mx_0_q),
    .din_i(din_0),
    .max_o(max_0),
    .q_o  (q_0)
  );

  l0_pool_sat #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_1 (
    .mx_i (mx_1_q),
    .din_i(din_1),
    .max_o(max_1),
    .q_o  (q_1)
  );

  ram #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(OUT_W)) u_ram_0 (
    .clk    (clk),
    .we_i   (wr),
    .waddr_i(wr_cnt_q[ADDR_W-1:0]),
    .wdata_i(q_0),
    .raddr_i(rd_addr),
    .rdata_o(dout_0)
  );

  ram #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(OUT_W)) u_ram_1 (
    .clk    (clk),
    .we_i   (wr),
    .waddr_i(wr_cnt_q[ADDR_W-1:0]),
    .wdata_i(q_1),
    .raddr_i(rd_addr),
    .rdata_o(dout_1)
  );

  // Next-state: tx_done wins; otherwise decode the beat against the window position.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    mx_0_d       = mx_0_q;
    mx_1_d       = mx_1_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    wr           = 1'b0;
    if (tx_done) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      wr_cnt_d   = '0;
      err_d      = 1'b0;
    end else if (win_vld && (state_q != DONE)) begin
      if (win_first) begin
        // A restart mid-window discards the partial max and flags framing.
        if (beat_cnt_q != 2'd0) begin
          err_d = 1'b1;
        end
        mx_0_d     = din_0;
        mx_1_d     = din_1;
        beat_cnt_d = 2'd1;
        state_d    = ACC;
      end else if ((state_q == IDLE) || (beat_cnt_q == 2'd0)) begin
        err_d = 1'b1;
      end else if (beat_cnt_q == 2'd3) begin
        wr         = 1'b1;
        beat_cnt_d = '0;
        wr_cnt_d   = wr_cnt_q + 1'b1;
        if (wr_cnt_q == LAST_WR) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end else begin
        mx_0_d     = max_0;
        mx_1_d     = max_1;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      wr_cnt_q     <= '0;
      mx_0_q       <= '0;
      mx_1_q       <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      mx_0_q       <= mx_0_d;
      mx_1_q       <= mx_1_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign rdy        = ({1'b0, rd_addr} < wr_cnt_q);
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
